// File: rtl/pt_arbiter.sv
// pt_arbiter: round-robin scheduler that shares the renderer point port
// (x/y/hue + req/ack) between N_SRC point generators. The winner's point is
// latched, forwarded on the renderer handshake, and then a one-cycle ack is
// returned to the winning source.
module pt_arbiter #(
   parameter int N_SRC = 4,
   parameter int IDW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_SRC-1:0]   src_en_i,
   input  logic [8*N_SRC-1:0] src_x_i,
   input  logic [8*N_SRC-1:0] src_y_i,
   input  logic [8*N_SRC-1:0] src_h_i,
   input  logic [N_SRC-1:0]   src_req_i,
   output logic [N_SRC-1:0]   src_ack_o,
   output logic [7:0]         pt_x_o,
   output logic [7:0]         pt_y_o,
   output logic [7:0]         pt_h_o,
   output logic               pt_req_o,
   input  logic               pt_ack_i,
   output logic [IDW-1:0]     grant_o,
   output logic               busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t           state_q;
   logic [IDW-1:0]   last_q;
   logic [IDW-1:0]   grant_q;
   logic [N_SRC-1:0] ack_q;
   logic [7:0]       x_q, y_q, h_q;
   logic             req_q;
   logic             busy_q;

   logic [N_SRC-1:0] elig;
   logic             hi_vld, lo_vld;
   logic [IDW-1:0]   hi_idx, lo_idx;
   logic             win_vld_d;
   logic [IDW-1:0]   win_d;
   logic [7:0]       win_x_d, win_y_d, win_h_d;
   logic [N_SRC-1:0] grant_oh;

   assign elig = src_req_i & src_en_i;

   // Round-robin pick: lowest eligible index above last wins, else lowest overall.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      hi_vld = 1'b0;
      lo_vld = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (elig[i]) begin
            if (i > int'(last_q)) begin
               if (!hi_vld) begin
                  hi_vld = 1'b1;
                  hi_idx = IDW'(i);
               end
            end else if (!lo_vld) begin
               lo_vld = 1'b1;
               lo_idx = IDW'(i);
            end
         end
      end
      win_vld_d = hi_vld | lo_vld;
      win_d     = hi_vld ? hi_idx : lo_idx;
   end

   // Point mux for the winner and one-hot decode of the current grant.
   always_comb begin
      win_x_d  = '0;
      win_y_d  = '0;
      win_h_d  = '0;
      grant_oh = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (IDW'(i) == win_d) begin
            win_x_d = src_x_i[8*i +: 8];
            win_y_d = src_y_i[8*i +: 8];
            win_h_d = src_h_i[8*i +: 8];
         end
         grant_oh[i] = (IDW'(i) == grant_q);
      end
   end

   // Arbitration FSM with registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= IDW'(N_SRC - 1);
         grant_q <= '0;
         ack_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         h_q     <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking default here is overridden by a later <= in the same
         // edge, which keeps the source ack to exactly one cycle.
         ack_q <= '0;
         case (state_q)
            IDLE: begin
               if (win_vld_d) begin
                  x_q     <= win_x_d;
                  y_q     <= win_y_d;
                  h_q     <= win_h_d;
                  grant_q <= win_d;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= FWD;
               end
            end
            FWD: begin
               if (pt_ack_i) begin
                  req_q   <= 1'b0;
                  ack_q   <= grant_oh;
                  last_q  <= grant_q;
                  state_q <= ACK;
               end
            end
            ACK: begin
               // Acked source still shows req this cycle, so no arbitration here.
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign src_ack_o = ack_q;
   assign pt_x_o    = x_q;
   assign pt_y_o    = y_q;
   assign pt_h_o    = h_q;
   assign pt_req_o  = req_q;
   assign grant_o   = grant_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_pt_arbiter.sv
// Testbench for pt_arbiter (N_SRC = 4): per-cycle vector table plus
// hand-written sequences for round-robin, long stall and mid-cycle reset.
module tb_pt_arbiter;

   localparam int N = 4;

   logic           clock;
   logic           reset;
   logic [N-1:0]   src_en_i;
   logic [8*N-1:0] src_x_i;
   logic [8*N-1:0] src_y_i;
   logic [8*N-1:0] src_h_i;
   logic [N-1:0]   src_req_i;
   logic [N-1:0]   src_ack_o;
   logic [7:0]     pt_x_o, pt_y_o, pt_h_o;
   logic           pt_req_o;
   logic           pt_ack_i;
   logic [1:0]     grant_o;
   logic           busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   pt_arbiter #(.N_SRC(N)) dut (
      .clock     (clock),
      .reset     (reset),
      .src_en_i  (src_en_i),
      .src_x_i   (src_x_i),
      .src_y_i   (src_y_i),
      .src_h_i   (src_h_i),
      .src_req_i (src_req_i),
      .src_ack_o (src_ack_o),
      .pt_x_o    (pt_x_o),
      .pt_y_o    (pt_y_o),
      .pt_h_o    (pt_h_o),
      .pt_req_o  (pt_req_o),
      .pt_ack_i  (pt_ack_i),
      .grant_o   (grant_o),
      .busy_o    (busy_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [3:0] en;
      logic [3:0] req;
      logic       ack;
      logic       e_req;
      logic [3:0] e_sack;
      logic       e_busy;
      logic [1:0] e_grant;
      logic [7:0] e_x;
      logic [7:0] e_y;
      logic [7:0] e_h;
   } vec_t;

   vec_t vecs[22];

   int exp_g[6];
   int rises, cyc, last_rise;
   logic [3:0] prev_ack;
   logic prev_req;
   int n_ack2;

   initial begin
      // Inputs of row i are applied before edge i; expectations hold after it.
      vecs[0]  = '{4'hF, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h10, 8'h20, 8'h64};
      vecs[1]  = '{4'hF, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h10, 8'h20, 8'h64};
      vecs[2]  = '{4'hF, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h10, 8'h20, 8'h64};
      vecs[3]  = '{4'hF, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h10, 8'h20, 8'h64};
      vecs[4]  = '{4'hF, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h10, 8'h20, 8'h64};
      vecs[5]  = '{4'hF, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h10, 8'h20, 8'h64};
      vecs[6]  = '{4'h0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h10, 8'h20, 8'h64};
      vecs[7]  = '{4'h0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h10, 8'h20, 8'h64};
      vecs[8]  = '{4'hA, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h11, 8'h21, 8'h65};
      vecs[9]  = '{4'hA, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h11, 8'h21, 8'h65};
      vecs[10] = '{4'hA, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'h11, 8'h21, 8'h65};
      vecs[11] = '{4'hA, 4'b1101, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h13, 8'h23, 8'h67};
      vecs[12] = '{4'hA, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h13, 8'h23, 8'h67};
      vecs[13] = '{4'hA, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h13, 8'h23, 8'h67};
      vecs[14] = '{4'hA, 4'b0111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h11, 8'h21, 8'h65};
      vecs[15] = '{4'h0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h11, 8'h21, 8'h65};
      vecs[16] = '{4'h0, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h11, 8'h21, 8'h65};
      vecs[17] = '{4'h0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 8'h11, 8'h21, 8'h65};
      vecs[18] = '{4'hA, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h13, 8'h23, 8'h67};
      vecs[19] = '{4'hA, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h13, 8'h23, 8'h67};
      vecs[20] = '{4'hA, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h13, 8'h23, 8'h67};
      vecs[21] = '{4'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h13, 8'h23, 8'h67};

      exp_g = '{0, 1, 2, 3, 0, 1};

      // Source k carries x = 0x10+k, y = 0x20+k, hue = 100+k.
      for (int k = 0; k < N; k++) begin
         src_x_i[8*k +: 8] = 8'(8'h10 + k);
         src_y_i[8*k +: 8] = 8'(8'h20 + k);
         src_h_i[8*k +: 8] = 8'(100 + k);
      end
      src_en_i  = '0;
      src_req_i = '0;
      pt_ack_i  = 1'b0;
      reset     = 1'b0;

      // ---- asynchronous reset, checked before any clock edge ----
      #1 reset = 1'b1;
      #2;
      check("reset pt_req", pt_req_o, 0);
      check("reset src_ack", src_ack_o, 0);
      check("reset busy", busy_o, 0);
      check("reset grant", grant_o, 0);
      check("reset pt_x", pt_x_o, 0);
      check("reset pt_y", pt_y_o, 0);
      check("reset pt_h", pt_h_o, 0);
      #15 reset = 1'b0;

      // ---- vector table ----
      for (int i = 0; i < 22; i++) begin
         src_en_i  = vecs[i].en;
         src_req_i = vecs[i].req;
         pt_ack_i  = vecs[i].ack;
         tick();
         check($sformatf("v%0d pt_req", i), pt_req_o, vecs[i].e_req);
         check($sformatf("v%0d src_ack", i), src_ack_o, vecs[i].e_sack);
         check($sformatf("v%0d busy", i), busy_o, vecs[i].e_busy);
         check($sformatf("v%0d grant", i), grant_o, vecs[i].e_grant);
         check($sformatf("v%0d pt_x", i), pt_x_o, vecs[i].e_x);
         check($sformatf("v%0d pt_y", i), pt_y_o, vecs[i].e_y);
         check($sformatf("v%0d pt_h", i), pt_h_o, vecs[i].e_h);
      end

      // ---- all four sources requesting, renderer acks one cycle after req ----
      src_en_i  = 4'hF;
      src_req_i = 4'hF;
      pt_ack_i  = 1'b0;
      prev_ack  = '0;
      prev_req  = 1'b0;
      rises     = 0;
      cyc       = 0;
      last_rise = 0;
      while (rises < 6 && cyc < 60) begin
         tick();
         cyc++;
         if (pt_req_o && !prev_req) begin
            check($sformatf("rr grant #%0d", rises), grant_o, exp_g[rises]);
            if (rises > 0) check($sformatf("rr gap #%0d", rises), cyc - last_rise, 4);
            last_rise = cyc;
            rises++;
         end
         if (src_ack_o != '0) begin
            check("rr ack onehot", $onehot(src_ack_o), 1);
            check("rr ack width", prev_ack, 0);
         end
         // A source drops req for one cycle after it has sampled its ack.
         src_req_i = ~prev_ack;
         prev_ack  = src_ack_o;
         pt_ack_i  = pt_req_o && prev_req && !pt_ack_i;
         prev_req  = pt_req_o;
      end
      check("rr grants seen", rises, 6);
      // Let the last transaction finish with no new requests.
      src_req_i = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         pt_ack_i = pt_req_o && prev_req && !pt_ack_i;
         prev_req = pt_req_o;
      end
      pt_ack_i = 1'b0;
      tick();
      check("rr drained busy", busy_o, 0);

      // ---- src 2 granted, renderer stalls 20 cycles while its data moves ----
      n_ack2 = 0;
      src_x_i[23:16] = 8'h55;
      src_req_i = 4'b0100;
      tick();
      check("stall grant", grant_o, 2);
      check("stall pt_req", pt_req_o, 1);
      check("stall pt_x", pt_x_o, 8'h55);
      for (int i = 0; i < 20; i++) begin
         src_x_i[23:16] = 8'(8'h60 + i);
         tick();
         if (src_ack_o[2]) n_ack2++;
         check($sformatf("stall c%0d pt_x", i), pt_x_o, 8'h55);
         check($sformatf("stall c%0d pt_req", i), pt_req_o, 1);
      end
      pt_ack_i = 1'b1;
      tick();
      if (src_ack_o[2]) n_ack2++;
      check("stall ack src_ack", src_ack_o, 4'b0100);
      check("stall ack pt_req", pt_req_o, 0);
      pt_ack_i = 1'b0;
      tick();
      if (src_ack_o[2]) n_ack2++;
      check("stall after src_ack", src_ack_o, 0);
      check("stall after busy", busy_o, 0);
      src_req_i = '0;
      tick();
      if (src_ack_o[2]) n_ack2++;
      check("stall ack2 pulses", n_ack2, 1);
      src_x_i[23:16] = 8'h12;

      // ---- reset asserted mid-cycle while in FWD ----
      src_req_i = 4'b0010;
      tick();
      check("rst pre grant", grant_o, 1);
      check("rst pre pt_req", pt_req_o, 1);
      #3 reset = 1'b1;
      #1;
      check("rst mid pt_req", pt_req_o, 0);
      check("rst mid busy", busy_o, 0);
      check("rst mid grant", grant_o, 0);
      check("rst mid src_ack", src_ack_o, 0);
      src_req_i = 4'b1000;
      #2 reset = 1'b0;
      tick();
      check("rst post grant", grant_o, 3);
      check("rst post pt_req", pt_req_o, 1);
      check("rst post pt_x", pt_x_o, 8'h13);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pt_arbiter.md
Name: pt_arbiter

Overview:
- Round-robin scheduler that shares one point-input port of a figure renderer (`fig_ring` point side: x/y/hue + req/ack) between N_SRC point generators (Lissajous/sweep sources).
- Grants one source at a time and latches its point.
- Drives the renderer's req/ack handshake, then returns a one-cycle ack to the granted source.
- Sits between the point generators and `fig_ring`.

Parameters:
- N_SRC, 4, number of point requesters (1..16).
- IDW, $clog2(N_SRC) (min 1), width of grant index.

Ports:
- clock  in  1  master clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- src_en_i  in  N_SRC  per-source enable mask; disabled sources are never granted
- src_x_i  in  8*N_SRC  point X, source k at bits [8k+7:8k]
- src_y_i  in  8*N_SRC  point Y, same packing
- src_h_i  in  8*N_SRC  point hue, same packing
- src_req_i  in  N_SRC  request level, held until matching ack
- src_ack_o  out  N_SRC  one-cycle ack pulse to granted source
- pt_x_o  out  8  latched point X to renderer
- pt_y_o  out  8  latched point Y
- pt_h_o  out  8  latched hue
- pt_req_o  out  1  request to renderer, held until pt_ack_i
- pt_ack_i  in  1  renderer ack pulse
- grant_o  out  IDW  index of current/last granted source
- busy_o  out  1  high while state != IDLE

Behaviour:
- Reset (async, asserted):
  - all outputs 0: src_ack_o, pt_x_o/pt_y_o/pt_h_o, pt_req_o, grant_o, busy_o.
  - internal last-grant pointer = N_SRC-1, so source 0 has first priority.
  - state = IDLE.
- All other logic is clocked on posedge clock. All outputs are registered.
- Handshake, both sides: requester raises req with stable data; responder pulses ack for exactly one cycle; requester drops req on the clock edge where it samples ack.
- State IDLE:
  - Eligible set = src_req_i & src_en_i.
  - Winner = first eligible index scanning last+1, last+2, ... modulo N_SRC.
  - If a winner exists, at the next edge: latch its x/y/h into pt_*_o, grant_o <= winner, pt_req_o <= 1, busy_o <= 1, state -> FWD.
  - If none, stay in IDLE; pt_*_o hold their previous values.
- State FWD:
  - pt_req_o stays high and pt_*_o stay stable.
  - On pt_ack_i = 1: pt_req_o <= 0, src_ack_o[grant_o] <= 1, last <= grant_o, state -> ACK.
  - Stall length is unbounded; there is no timeout.
- State ACK (one cycle):
  - src_ack_o <= 0, busy_o <= 0, state -> IDLE.
  - src_req_i is not sampled for arbitration here, because the acked source still shows req in this cycle.
- Latency:
  - Request sampled in cycle c → pt_req_o high in c+1.
  - pt_ack_i in cycle d → pt_req_o low and src_ack_o high in d+1; IDLE in d+2.
  - Earliest next pt_req_o rise is d+3.
- Boundary conditions:
  - pt_ack_i while in IDLE or ACK: ignored.
  - src_en_i or src_req_i dropped during FWD: the transaction still completes and the ack is still pulsed to grant_o.
  - Data inputs changing after grant: no effect; values were latched in IDLE.
  - N_SRC = 1: degenerates to a registered pass-through; grant_o is always 0.
  - All sources disabled: no grants; pt_req_o stays 0.
  - Reset during FWD/ACK: pt_req_o and src_ack_o drop asynchronously; the pending point is discarded.
- Fairness: a continuously requesting source waits at most N_SRC-1 other transactions.

Test Plan:
- Only src 0 requests (x=0x10, y=0x20, h=100), renderer acks 1 cycle after req; en=4'hF → pt_req_o rises 1 cycle after src_req_i; pt_x/y/h_o = 0x10/0x20/100; src_ack_o=4'b0001 for exactly 1 cycle; busy_o low 2 cycles after pt_ack_i.
- All 4 sources request continuously, each re-requesting after its ack, renderer acks immediately → grant_o sequence 0,1,2,3,0,1; each src_ack_o pulse one cycle wide; pt_req_o rises every 4 cycles.
- src_en_i=4'b1010, all requesting → grants alternate 1,3,1,3; src_ack_o[0] and src_ack_o[2] never pulse.
- Src 2 granted with x=0x55, renderer withholds pt_ack_i 20 cycles while src_x_i changes each cycle → pt_x_o stays 0x55; pt_req_o high all 20 cycles; single src_ack_o[2] pulse after ack.
- Reset asserted mid-clock during FWD → pt_req_o, busy_o, grant_o go 0 before the next edge; after release with src 3 requesting, src 3 is granted via the 0-first scan.
- pt_ack_i pulsed while IDLE with no requests → no src_ack_o pulse, state stays IDLE, busy_o=0.
